// File: rtl/msk_pkg.sv
// Shared definitions for the masked elastic pipeline.
package msk_pkg;

  localparam int unsigned DEF_D      = 2;
  localparam int unsigned DEF_COUNT  = 8;
  localparam int unsigned DEF_STAGES = 3;

  // Width of an occupancy count able to hold 0..stages
  function automatic int unsigned level_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

  localparam int unsigned LEVEL_W = $clog2(DEF_STAGES + 1);

  // Flat position of share j of unshared bit i
  function automatic int unsigned share_idx(input int unsigned bit_i,
                                            input int unsigned share_j,
                                            input int unsigned d);
    return bit_i * d + share_j;
  endfunction

endpackage

// File: rtl/msk_stage_bt.sv
// One masked pipeline stage: holds a shared word, refreshes it on capture,
// and flushes on the Borrowed-Time clear.
module msk_stage_bt
  import msk_pkg::*;
#(
  parameter int unsigned d     = DEF_D,
  parameter int unsigned count = DEF_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 src_valid,
  input  logic [count*d-1:0]   src_data,
  input  logic [count-1:0]     rnd,
  output logic                 valid,
  output logic [count*d-1:0]   data,
  output logic                 valid_nxt_c
);

  localparam int unsigned W = count * d;

  logic [W-1:0] data_q, data_d, fresh_c;
  logic         valid_q, valid_d;

  // Share refresh: the same random bit lands on shares 0 and 1, so the
  // unshared value is unchanged while the representation is re-randomised.
  if (d >= 2) begin : g_refresh
    always_comb begin
      fresh_c = src_data;
      for (int unsigned i = 0; i < count; i++) begin
        fresh_c[share_idx(i, 0, d)] = src_data[share_idx(i, 0, d)] ^ rnd[i];
        fresh_c[share_idx(i, 1, d)] = src_data[share_idx(i, 1, d)] ^ rnd[i];
      end
    end
  end else begin : g_pass
    assign fresh_c = src_data;
  end

  // Next state: clear beats load; an invalid source leaves dead data untouched
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = src_valid;
      if (src_valid) begin
        data_d = fresh_c;
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid       = valid_q;
  assign data        = data_q;
  assign valid_nxt_c = valid_d;

endmodule

// File: rtl/msk_pipe_bt.sv
// Elastic multi-stage masked register pipeline with valid/ready flow control,
// per-stage share refresh, occupancy count and synchronous clear.
module msk_pipe_bt
  import msk_pkg::*;
#(
  parameter  int unsigned d      = DEF_D,
  parameter  int unsigned count  = DEF_COUNT,
  parameter  int unsigned STAGES = DEF_STAGES,
  localparam int unsigned LW     = level_width(STAGES),
  localparam int unsigned W      = count * d
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in,
  input  logic [STAGES*count-1:0]   rnd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out,
  output logic [LW-1:0]             level
);

  logic [STAGES-1:0] v_c, v_nxt_c, load_c, src_v_c;
  logic [W-1:0]      stage_data [STAGES];
  logic [W-1:0]      src_data   [STAGES];
  logic [LW-1:0]     level_q, level_d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v_c[k]  = in_valid;
      assign src_data[k] = in;
    end else begin : g_body
      assign src_v_c[k]  = v_c[k-1];
      assign src_data[k] = stage_data[k-1];
    end

    msk_stage_bt #(
      .d     (d),
      .count (count)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .load        (load_c[k]),
      .src_valid   (src_v_c[k]),
      .src_data    (src_data[k]),
      .rnd         (rnd[k*count +: count]),
      .valid       (v_c[k]),
      .data        (stage_data[k]),
      .valid_nxt_c (v_nxt_c[k])
    );
  end

  // Ready chain from the output back: a stage advances if empty or if its
  // successor advances, so a full pipe still moves one word per cycle.
  always_comb begin
    logic acc;
    load_c = '0;
    acc    = ~v_c[STAGES-1] | out_ready;
    load_c[STAGES-1] = acc;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      acc       = ~v_c[k] | acc;
      load_c[k] = acc;
    end
  end

  // Occupancy follows the valid bits that the coming edge will register
  always_comb begin
    level_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      level_d = level_d + LW'(v_nxt_c[k]);
    end
  end

  // Occupancy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign in_ready  = load_c[0] & ~clear;
  assign out_valid = v_c[STAGES-1];
  assign out       = stage_data[STAGES-1];
  assign level     = level_q;

endmodule

// File: doc/msk_pipe_bt.md
Name: msk_pipe_bt

Overview:
- Elastic, multi-stage pipeline of masked registers with a valid/ready handshake, per-stage share refresh, and a Borrowed-Time clear.
- It is the parametrised successor to the single-stage enabled masked register. It adds depth, flow control, occupancy tracking and randomness refresh on capture.
- It sits between masked datapath rounds, for example the SKINNY state and key paths, where it buffers shared words without ever recombining shares.

Parameters:
- d, 2, number of shares per bit (d >= 1).
- count, 8, number of unshared bits per word.
- STAGES, 3, pipeline depth (STAGES >= 1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous Borrowed-Time clear; flushes all stages.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage 0 can accept this cycle.
- in  in  count*d  masked word; shares of bit i occupy in[i*d +: d], share j at in[i*d+j].
- rnd  in  STAGES*count  fresh randomness; stage k uses rnd[k*count +: count].
- out_valid  out  1  valid flag of the last stage.
- out_ready  in  1  downstream accepts.
- out  out  count*d  data of the last stage, same share layout as in.
- level  out  $clog2(STAGES+1)  number of valid stages.

Behaviour:

State and reset
- Per stage k: data_k (count*d) and v_k (1 bit).
- Reset (async, rst=1): every data_k=0 and v_k=0, so out=0, out_valid=0, level=0.
- Immediately after reset, in_ready=1 (combinational).

Load (advance) conditions
- load_{STAGES-1} = !v_{STAGES-1} | out_ready.
- load_k = !v_k | load_{k+1} for k < STAGES-1.
- This is a combinational ready chain with no bubble penalty: a full pipe with out_ready=1 moves one word per cycle.
- in_ready = load_0 & !clear.

Stage update on load_k (no clear)
- v_k <= source valid, where the source is in_valid for k=0 and v_{k-1} otherwise.
- If the source is valid: data_k <= refresh(source data, rnd stage k).
  - For each bit i: share 0 ^= rnd[k*count+i], share 1 ^= rnd[k*count+i]; other shares pass unchanged.
  - The unshared value is preserved.
- If the source is invalid: data_k holds its value (no toggling of dead data).
- d=1: refresh is a no-op and rnd is ignored.
- No load_k: data_k and v_k hold.

Clear
- clear=1 is synchronous and has highest priority over loads.
- Next edge: all v_k=0 and all data_k=0.
- in_ready=0 during the clear cycle; the in_valid word is dropped and out handshake completions are not honoured.
- clear held for multiple cycles keeps the pipe empty.

Timing and outputs
- Latency: a word accepted at edge t appears on out after edge t+STAGES-1 when the pipe is empty ahead of it, i.e. STAGES edges through the pipe.
- Transfers: upstream transfer = in_valid & in_ready; downstream transfer = out_valid & out_ready.
- Words are never duplicated or reordered.
- Stall: with out_ready=0, stages fill back to front; in_ready falls only when all STAGES are valid.
- Simultaneous: with the pipe full, out_ready=1 and in_valid=1, a word is accepted and a word is emitted in the same cycle; level is unchanged.
- level: registered popcount of v_k, updated every edge; reset value 0.
- Reset mid-operation: all words are discarded immediately and asynchronously; rnd is ignored while rst=1.

Decomposition:
- Shared package msk_pkg:
  - share index helper function (bit i, share j -> i*d+j);
  - localparam LEVEL_W = $clog2(STAGES+1).
- One sub-module, msk_stage_bt: a single stage holding data, valid, refresh XOR and clear. It is instantiated STAGES times in a generate loop.
- The ready chain and level counter live in the top module.

Test Plan:
All scenarios use d=2, count=4, STAGES=3.

1. Reset then single word.
   - Stimulus: rst pulse; send in=8'hA5 with rnd=0, out_ready=1.
   - Required: out_valid rises 3 edges after acceptance; out=8'hA5; level goes 1,1,1 then 0 after output.
2. Refresh correctness.
   - Stimulus: send unshared 4'hC; rnd per stage 4'h3, 4'h5, 4'h9.
   - Required: the XOR of shares per bit on out equals 4'hC; raw out equals the input shares with shares 0 and 1 each XORed with 4'hF (3^5^9=F).
3. Backpressure.
   - Stimulus: out_ready=0; offer 4 consecutive words.
   - Required: 3 accepted; in_ready=0 on the 4th; level=3; raising out_ready drains the words in order, one per cycle.
4. Full-throughput simultaneous transfer.
   - Stimulus: pipe full, in_valid=1 and out_ready=1 for 10 cycles.
   - Required: 10 in, 10 out; level stays 3; order preserved.
5. Clear mid-stream.
   - Stimulus: level=2; assert clear for 1 cycle with in_valid=1.
   - Required: in_ready=0 that cycle; next cycle level=0, out_valid=0, out=0; the offered word is lost.
6. Async reset mid-stream.
   - Stimulus: assert rst between clock edges with the pipe full.
   - Required: out_valid=0 and out=0 before the next edge.
